des_req_arbiter: RTL and testbench

//  Shares one des_top encrypt/decrypt core between two independent requesters (port 0, port 1).

---
 rtl/des_req_arbiter_pkg.sv | 18 +
 rtl/des_req_arbiter_if.sv | 36 +++
 rtl/des_req_arbiter_rr_arb2.sv | 20 ++
 rtl/des_req_arbiter.sv | 110 +++++++++++
 tb/tb_des_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_req_arbiter_pkg.sv
// Shared types for the two-port DES request arbiter: FSM state encoding and port ids.
package des_req_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2,
    StResp     = 2'd3
  } state_e;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == Port1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/des_req_arbiter_if.sv
// Requester and core-side signals of the DES request arbiter, grouped as one bundle.
interface des_req_arbiter_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_enc_dec;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              core_start;
  logic              core_enc_dec;
  logic [DATA_W-1:0] core_data_in;
  logic [DATA_W-1:0] core_data_out;
  logic              core_done;
  logic              core_busy;

  modport slave (
    input  req_valid, req_enc_dec, req_data0, req_data1, rsp_ready,
    input  core_data_out, core_done, core_busy,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output core_start, core_enc_dec, core_data_in
  );

  modport master (
    output req_valid, req_enc_dec, req_data0, req_data1, rsp_ready,
    output core_data_out, core_done, core_busy,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  core_start, core_enc_dec, core_data_in
  );

endinterface

// File: rtl/des_req_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester wins, a tie goes to rr_ptr.
module des_req_arbiter_rr_arb2
  import des_req_arbiter_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = port_onehot(rr_ptr);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/des_req_arbiter.sv
// Shares one DES core between two requesters: one operation in flight, round-robin fairness,
// watchdog turns a hung core into an error response.
module des_req_arbiter
  import des_req_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst_n,
  des_req_arbiter_if.slave bus
);

  localparam int unsigned     WdogW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              enc_q, enc_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        grant;
  logic [1:0]        ready;

  des_req_arbiter_rr_arb2 u_rr_arb2 (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_q),
    .grant     (grant)
  );

  // A core still draining its previous job holds off every grant.
  assign ready            = (state_q == StIdle && !bus.core_busy) ? grant : 2'b00;
  assign bus.req_ready    = ready;
  assign bus.core_start   = (state_q == StIssue);
  assign bus.core_enc_dec = enc_q;
  assign bus.core_data_in = din_q;
  assign bus.rsp_valid    = (state_q == StResp) ? port_onehot(gnt_q) : 2'b00;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    wdog_d     = wdog_q;
    enc_d      = enc_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if ((ready & bus.req_valid) != 2'b00) begin
          gnt_d   = ready[1];
          enc_d   = ready[1] ? bus.req_enc_dec[1] : bus.req_enc_dec[0];
          din_d   = ready[1] ? bus.req_data1 : bus.req_data0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.core_done) begin
          rsp_data_d = bus.core_data_out;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (wdog_d == WdogMax) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready[gnt_q]) begin
          rr_d    = ~gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= Port0;
      rr_q       <= Port0;
      wdog_q     <= '0;
      enc_q      <= 1'b1;
      din_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      wdog_q     <= wdog_d;
      enc_q      <= enc_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_des_req_arbiter.sv
// Bench for des_req_arbiter: stub DES core, directed tests, and a per-cycle reference model.
module tb_des_req_arbiter;

  localparam int unsigned TO = 20;
  localparam logic [63:0] CoreKey = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] PT      = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT      = 64'h2C4A_6886_A4C2_E00E;
  localparam logic [63:0] DA      = 64'h1111_2222_3333_4444;
  localparam logic [63:0] CA      = 64'h1E2D_2D3C_3C4B_4B1E;
  localparam logic [63:0] DB      = 64'h5555_6666_7777_8888;
  localparam logic [63:0] CB      = 64'h5A69_6978_7887_875A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_req_arbiter_if #(.DATA_W(64)) bus ();

  des_req_arbiter #(.DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int hs_cyc = 0;
  int rsp_cyc = 0;

  // Stand-in core: rotate-and-xor, inverse for decrypt, fixed latency, can be told to hang.
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic enc);
    logic [63:0] t;
    if (enc) return {d[55:0], d[63:56]} ^ CoreKey;
    t = d ^ CoreKey;
    return {t[7:0], t[63:8]};
  endfunction

  int          lat = 6;
  logic        hang = 1'b0;
  logic        force_busy = 1'b0;
  logic        spur_done = 1'b0;
  int          cnt;
  logic        stub_done;
  logic [63:0] stub_res, stub_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 0;
      stub_done <= 1'b0;
      stub_res  <= '0;
      stub_out  <= '0;
    end else begin
      stub_done <= 1'b0;
      if (bus.core_start && !hang) begin
        cnt      <= lat;
        stub_res <= core_fn(bus.core_data_in, bus.core_enc_dec);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          stub_done <= 1'b1;
          stub_out  <= stub_res;
        end
      end
    end
  end

  assign bus.core_done     = stub_done | spur_done;
  assign bus.core_busy     = (cnt != 0) | force_busy;
  assign bus.core_data_out = spur_done ? 64'hBAD0_BAD0_BAD0_BAD0 : stub_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input int fav);
    if (v == 2'b11) return (fav == 1) ? 2'b10 : 2'b01;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference model: one job at a time; a finished job waits for its owner's rsp_ready;
  // the port not served last wins a tie.
  initial begin : compare
    logic        m_pend, m_have, m_err, m_enc;
    int          m_port, m_since, m_fav;
    logic [63:0] m_data, m_res;
    logic [1:0]  exp_ready, exp_rv;
    m_pend = 0; m_have = 0; m_err = 0; m_enc = 1; m_port = 0; m_since = 0; m_fav = 0;
    m_data = '0; m_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 0; m_have = 0; m_fav = 0;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_core_start", 64'(bus.core_start), 64'd0);
        chk("rst_core_enc_dec", 64'(bus.core_enc_dec), 64'd1);
        chk("rst_core_data_in", bus.core_data_in, 64'd0);
      end else begin
        if (m_pend) m_since++;
        exp_ready = (!m_pend && !bus.core_busy) ? pick(bus.req_valid, m_fav) : 2'b00;
        exp_rv = m_have ? ((m_port == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("m_core_start", 64'(bus.core_start), 64'(m_pend && m_since == 1));
        chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (m_have) begin
          chk("m_rsp_data", bus.rsp_data, m_res);
          chk("m_rsp_err", 64'(bus.rsp_err), 64'(m_err));
        end
        if (m_pend && m_since >= 1) begin
          chk("m_core_data_in", bus.core_data_in, m_data);
          chk("m_core_enc_dec", 64'(bus.core_enc_dec), 64'(m_enc));
        end
        if (bus.core_start) begin
          start_cnt++;
          start_cyc = cyc;
        end
        if (m_have) begin
          if (bus.rsp_ready[m_port]) begin
            m_pend = 0;
            m_have = 0;
            m_fav  = (m_port == 0) ? 1 : 0;
          end
        end else if (m_pend && m_since >= 2) begin
          if (bus.core_done) begin
            m_have = 1; m_err = 0; m_res = core_fn(m_data, m_enc);
          end else if (m_since - 1 == int'(TO)) begin
            m_have = 1; m_err = 1; m_res = '0;
          end
        end else if (!m_pend && exp_ready != 2'b00) begin
          m_pend  = 1;
          m_since = 0;
          m_port  = exp_ready[1] ? 1 : 0;
          m_enc   = bus.req_enc_dec[m_port];
          m_data  = (m_port == 1) ? bus.req_data1 : bus.req_data0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string nm, output int port);
    bit got = 0;
    port = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != 2'b00) begin
        got    = 1;
        hs_cyc = cyc;
        port   = bus.req_ready[1] ? 1 : 0;
      end
      step();
    end
    if (got) bus.req_valid[port] = 1'b0;
    else fail_bound(nm);
  endtask

  task automatic wait_rsp(input string nm, input int p, input logic [63:0] d, input logic e);
    bit got = 0;
    for (int i = 0; i < int'(TO) + 60 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        got     = 1;
        rsp_cyc = cyc;
        chk({nm, "_valid"}, 64'(bus.rsp_valid), (p == 1) ? 64'd2 : 64'd1);
        chk({nm, "_data"}, bus.rsp_data, d);
        chk({nm, "_err"}, 64'(bus.rsp_err), 64'(e));
      end
      step();
    end
    if (!got) fail_bound(nm);
  endtask

  initial begin : main
    int p, s0, seen;
    bus.req_valid = 2'b00; bus.req_enc_dec = 2'b00;
    bus.req_data0 = '0;    bus.req_data1 = '0;
    bus.rsp_ready = 2'b11;
    repeat (3) step();
    rst_n = 1'b1;

    // 1: port 0 encrypt, single start pulse one cycle after the handshake
    s0 = start_cnt;
    bus.req_enc_dec[0] = 1'b1; bus.req_data0 = PT; bus.req_valid[0] = 1'b1;
    wait_hs("t1_hs", p);
    chk("t1_port", 64'(p), 64'd0);
    wait_rsp("t1_rsp", 0, CT, 1'b0);
    chk("t1_start_lat", 64'(start_cyc - hs_cyc), 64'd1);
    chk("t1_start_cnt", 64'(start_cnt - s0), 64'd1);

    // 2: port 1 decrypt returns the plaintext
    bus.req_enc_dec[1] = 1'b0; bus.req_data1 = CT; bus.req_valid[1] = 1'b1;
    wait_hs("t2_hs", p);
    chk("t2_port", 64'(p), 64'd1);
    wait_rsp("t2_rsp", 1, PT, 1'b0);

    // 3: contention straight after reset, grants alternate 0,1,0,1
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    bus.req_enc_dec = 2'b11; bus.req_data0 = DA; bus.req_data1 = DB;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_hs("t3_hs", p);
      chk("t3_order", 64'(p), 64'(k % 2));
      wait_rsp("t3_rsp", p, (p == 1) ? CB : CA, 1'b0);
      if (k < 3 && p >= 0) bus.req_valid[p] = 1'b1;
    end
    bus.req_valid = 2'b00;

    // 4: response stalled for 10 cycles while port 1 waits
    bus.rsp_ready = 2'b10;
    bus.req_enc_dec[0] = 1'b1; bus.req_data0 = PT; bus.req_valid[0] = 1'b1;
    wait_hs("t4_hs", p);
    bus.req_enc_dec[1] = 1'b1; bus.req_data1 = DA; bus.req_valid[1] = 1'b1;
    wait_rsp("t4_rsp", 0, CT, 1'b0);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_data", bus.rsp_data, CT);
      chk("t4_hold_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    chk("t4_no_start", 64'(start_cnt - s0), 64'd0);
    bus.rsp_ready = 2'b11;
    step();
    wait_hs("t4_hs1", p);
    chk("t4_port1", 64'(p), 64'd1);
    wait_rsp("t4_rsp1", 1, CA, 1'b0);

    // busy core blocks grants; a stray done in idle is ignored
    hang = 1'b1; force_busy = 1'b1;
    bus.req_enc_dec[0] = 1'b1; bus.req_data0 = DA; bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_block", 64'(bus.req_ready), 64'd0);
      step();
      spur_done = (i == 0);
    end
    spur_done = 1'b0;
    force_busy = 1'b0;

    // 5: hung core, error exactly TO+1 cycles after the start pulse
    wait_hs("t5_hs", p);
    wait_rsp("t5_rsp", 0, 64'd0, 1'b1);
    chk("t5_timeout_lat", 64'(rsp_cyc - start_cyc), 64'(TO + 1));
    hang = 1'b0;
    bus.req_enc_dec[1] = 1'b0; bus.req_data1 = CA; bus.req_valid[1] = 1'b1;
    wait_hs("t5_hs1", p);
    wait_rsp("t5_rsp1", 1, DA, 1'b0);

    // 6: asynchronous reset while waiting on the core
    lat = 15;
    bus.req_enc_dec[0] = 1'b0; bus.req_data0 = CT; bus.req_valid[0] = 1'b1;
    wait_hs("t6_hs", p);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t6_async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6_async_core_enc_dec", 64'(bus.core_enc_dec), 64'd1);
    chk("t6_async_core_data_in", bus.core_data_in, 64'd0);
    chk("t6_async_core_start", 64'(bus.core_start), 64'd0);
    step();
    rst_n = 1'b1;
    lat = 6;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) seen++;
      step();
    end
    chk("t6_no_stale", 64'(seen), 64'd0);
    bus.req_enc_dec[1] = 1'b1; bus.req_data1 = PT; bus.req_valid[1] = 1'b1;
    wait_hs("t6_hs1", p);
    chk("t6_port1", 64'(p), 64'd1);
    wait_rsp("t6_rsp1", 1, CT, 1'b0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
